proj_qsys_jtag_scan_master: RTL and testbench
=============================================

PROJ_QSYS_JTAG_SCAN_MASTER -- requirements
Module: proj_qsys_jtag_scan_master

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; no other clock or reset SHALL be used.
REQ-002 Parameter: TCK_DIV, default 4, meaning clk cycles per TCK half-period (legal range 1..255).
REQ-003 Parameter: MAX_LEN, default 38, meaning the maximum scan length in bits.
REQ-004 clk  in  1  system clock; every register is clocked on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  block is idle and accepts a command.
REQ-008 cmd_op  in  2  operation: 00 = DR scan, 01 = IR scan, 10 = TAP reset, 11 = reserved.
REQ-009 cmd_len  in  6  scan length in bits, legal 1..MAX_LEN.
REQ-010 cmd_data  in  MAX_LEN  bits shifted out on tdi, LSB first.
REQ-011 rsp_valid  out  1  one-cycle pulse that marks command completion.
REQ-012 rsp_err  out  1  qualifies rsp_valid; 1 = command rejected.
REQ-013 rsp_data  out  MAX_LEN  captured tdo bits, right-aligned.
REQ-014 busy  out  1  a scan is in progress.
REQ-015 tck, tms, tdi  out  1 each  JTAG host pins; tdo  in  1, already synchronous to clk.

Function
REQ-016 A command SHALL be accepted on a clk edge where cmd_valid=1 and cmd_ready=1; cmd_ready SHALL be 0 from acceptance until the cycle after rsp_valid.
REQ-017 The block SHALL register cmd_op, cmd_len and cmd_data at acceptance; later input changes SHALL have no effect on the command in progress.
REQ-018 Each TCK cycle SHALL be a low phase of TCK_DIV clks followed by a high phase of TCK_DIV clks.
REQ-019 tms and tdi SHALL change only at the clk edge where tck goes low.
REQ-020 tdo SHALL be sampled at the clk edge where tck goes high.
REQ-021 The block SHALL start every operation from Run-Test/Idle and return to Run-Test/Idle.
REQ-022 States: IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RST.
REQ-023 A DR scan SHALL drive this TMS sequence: 1 (SEL_DR), 0 (CAPTURE), 0 (enter SHIFT), then N shift cycles with TMS=0 except TMS=1 on the last bit (EXIT1), then 1 (UPDATE), then 0 (IDLE); total N+5 TCK cycles.
REQ-024 An IR scan SHALL follow REQ-023 with an extra leading TMS=1 (SEL_IR); total N+6 TCK cycles.
REQ-025 TAP reset SHALL drive five TCK cycles with TMS=1, then one with TMS=0; total 6 TCK cycles; rsp_data=0.
REQ-026 tdi SHALL carry cmd_data[k] during shift cycle k (k=0..N-1); tdi SHALL be 0 outside SHIFT.
REQ-027 The tdo bit sampled in shift cycle k SHALL land in rsp_data[k]; rsp_data[MAX_LEN-1:N] SHALL be 0.
REQ-028 rsp_valid SHALL pulse for one clk at the clk edge that ends the final TCK high phase, with tck=0 at that edge; rsp_data and rsp_err SHALL hold until the next rsp_valid.
REQ-029 With cmd_op=11, cmd_len=0 or cmd_len>MAX_LEN, the block SHALL toggle no pins, SHALL pulse rsp_valid with rsp_err=1 one clk after acceptance, and SHALL leave rsp_data unchanged.
REQ-030 busy SHALL be 1 from the cycle after acceptance through the rsp_valid cycle, inclusive.
REQ-031 rsp_valid SHALL have no backpressure; a new command SHALL be acceptable in the cycle after rsp_valid.
REQ-032 TCK_DIV=1 SHALL yield tck = clk/2, with timing otherwise identical.

Reset
REQ-033 While reset=1, outputs SHALL be: tck=0, tms=1, tdi=0, cmd_ready=0, busy=0, rsp_valid=0, rsp_err=0, rsp_data=0; the state SHALL be IDLE.
REQ-034 In the first cycle after reset deasserts, cmd_ready SHALL be 1.
REQ-035 Reset mid-scan SHALL abort immediately with no rsp_valid; the TAP state is then undefined, and software SHALL issue a TAP reset.

Verification
REQ-036 Loopback (tdo=tdi), TCK_DIV=4, DR scan len=8, data=0xA5 -> 13 TCK cycles, rsp_valid 104 clks after acceptance, rsp_data=0xA5, rsp_err=0.
REQ-037 IR scan len=2, data=2'b10, tdo tied 1 -> TMS 1,1,0,0,0,1,1,0 (8 TCK cycles), rsp_data=0x3.
REQ-038 TAP reset -> TMS 1,1,1,1,1,0, tdi held 0, rsp_data=0.
REQ-039 cmd_len=0, then cmd_len=39, then cmd_op=11 -> each gives rsp_err=1 one clk after acceptance, tck stays 0, rsp_data unchanged.
REQ-040 Loopback DR scan len=38, data=0x2A_5A5A5A5A, with reset asserted at TCK cycle 20 -> no rsp_valid, outputs at reset values; a following len=38 scan returns 0x2A_5A5A5A5A.
REQ-041 Back-to-back: cmd_valid held high with two DR commands -> second accepted the cycle after the first rsp_valid, with no extra TCK cycle between scans.

Source files
------------

// File: rtl/proj_qsys_jtag_scan_master.sv
// JTAG scan master: accepts DR/IR scan and TAP-reset commands, bit-bangs
// tck/tms/tdi at clk/(2*TCK_DIV) and returns captured tdo bits right-aligned.
module proj_qsys_jtag_scan_master #(
  parameter int TCK_DIV = 4,
  parameter int MAX_LEN = 38
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam logic [1:0] OP_DR  = 2'b00;
  localparam logic [1:0] OP_IR  = 2'b01;
  localparam logic [1:0] OP_RST = 2'b10;

  // Scan states name the TAP state occupied during the current TCK cycle;
  // RTI is the first cycle of a scan (TAP still in Run-Test/Idle).
  typedef enum logic [3:0] {
    IDLE, RTI, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RST, ERR
  } state_t;

  state_t state, state_next;

  logic [7:0]         div_cnt;
  logic [5:0]         bit_cnt;
  logic [1:0]         op_q;
  logic [5:0]         len_q;
  logic [MAX_LEN-1:0] sh_q;
  logic [MAX_LEN-1:0] cap_q;

  logic accept, cmd_bad, scanning, phase_end, tck_rise, tck_fall;
  logic last_bit, scan_done;

  assign accept    = cmd_valid && cmd_ready;
  assign cmd_bad   = (cmd_op == 2'b11) || (cmd_len == 6'd0) || (32'(cmd_len) > MAX_LEN);
  assign scanning  = (state != IDLE) && (state != ERR);
  assign phase_end = (div_cnt == 8'(TCK_DIV - 1));
  assign tck_rise  = scanning && !tck && phase_end;
  assign tck_fall  = scanning &&  tck && phase_end;
  assign last_bit  = (bit_cnt == len_q - 6'd1);
  assign scan_done = tck_fall && ((state == UPDATE) || (state == RST && bit_cnt == 6'd5));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: defaults first so every path assigns state_next and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) begin
        if (cmd_bad)               state_next = ERR;
        else if (cmd_op == OP_RST) state_next = RST;
        else                       state_next = RTI;
      end
      ERR:     state_next = IDLE;
      RTI:     if (tck_fall) state_next = SEL_DR;
      SEL_DR:  if (tck_fall) state_next = (op_q == OP_IR) ? SEL_IR : CAPTURE;
      SEL_IR:  if (tck_fall) state_next = CAPTURE;
      CAPTURE: if (tck_fall) state_next = SHIFT;
      SHIFT:   if (tck_fall && last_bit) state_next = EXIT1;
      EXIT1:   if (tck_fall) state_next = UPDATE;
      UPDATE:  if (tck_fall) state_next = IDLE;
      RST:     if (tck_fall && bit_cnt == 6'd5) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // tms/tdi derive from registers that only move on the tck falling edge.
  always_comb begin
    tms = 1'b1;
    tdi = 1'b0;
    unique case (state)
      SEL_DR:  tms = (op_q == OP_IR);
      SEL_IR:  tms = 1'b0;
      CAPTURE: tms = 1'b0;
      SHIFT: begin
        tms = last_bit;
        tdi = sh_q[0];
      end
      UPDATE:  tms = 1'b0;
      RST:     tms = (bit_cnt != 6'd5);
      default: tms = 1'b1;
    endcase
    busy      = (state != IDLE) || rsp_valid;
    cmd_ready = !reset && (state == IDLE) && !rsp_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tck       <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      op_q      <= OP_DR;
      len_q     <= '0;
      sh_q      <= '0;
      cap_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        op_q    <= cmd_op;
        len_q   <= cmd_len;
        sh_q    <= cmd_data;
        cap_q   <= '0;
        bit_cnt <= '0;
        div_cnt <= '0;
        tck     <= 1'b0;
      end else if (scanning) begin
        if (phase_end) begin
          div_cnt <= '0;
          tck     <= ~tck;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
        if (tck_rise && state == SHIFT) cap_q[bit_cnt] <= tdo;
        if (tck_fall && (state == SHIFT || state == RST)) bit_cnt <= bit_cnt + 6'd1;
        if (tck_fall && state == SHIFT) sh_q <= sh_q >> 1;
        if (scan_done) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_data  <= cap_q;
        end
      end else if (state == ERR) begin
        // Rejected command: rsp_data keeps the previous result.
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_proj_qsys_jtag_scan_master.sv
// Directed self-checking bench for proj_qsys_jtag_scan_master (TCK_DIV=4,
// MAX_LEN=38); pin activity is sampled on the falling clk edge.
module tb_proj_qsys_jtag_scan_master;

  localparam int ML = 38;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [5:0]    cmd_len;
  logic [ML-1:0] cmd_data;
  logic          rsp_valid, rsp_err, busy, tck, tms, tdi, tdo;
  logic [ML-1:0] rsp_data;
  logic          loopback, tdo_fix;

  int tests = 0;
  int fails = 0;

  assign tdo = loopback ? tdi : tdo_fix;

  always #5 clk = ~clk;

  proj_qsys_jtag_scan_master #(.TCK_DIV(4), .MAX_LEN(ML)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Results of the last watch() call.
  logic [63:0] w_tms, w_tdi;
  int          w_lat, w_ntck;
  logic        w_got, w_busy1, w_ready1, w_busy_rsp, w_ready_rsp, w_tck_rsp;

  // Present a command, confirm it is accepted, then scramble the inputs.
  task automatic send(input logic [1:0] op, input logic [5:0] len, input logic [ML-1:0] data);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    check("ready_before_accept", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_len   = 6'($urandom);
    cmd_data  = ML'({$urandom, $urandom});
  endtask

  // Follow one command from the acceptance edge until rsp_valid or budget expiry.
  task automatic watch(input int budget);
    logic prev;
    prev   = 1'b0;
    w_tms  = '0;
    w_tdi  = '0;
    w_lat  = -1;
    w_ntck = 0;
    w_got  = 1'b0;
    w_busy1 = 1'b0; w_ready1 = 1'b1;
    w_busy_rsp = 1'b0; w_ready_rsp = 1'b1; w_tck_rsp = 1'b1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        w_busy1  = busy;
        w_ready1 = cmd_ready;
      end
      if (tck && !prev) begin
        if (w_ntck < 64) begin
          w_tms[w_ntck] = tms;
          w_tdi[w_ntck] = tdi;
        end
        w_ntck++;
      end
      prev = tck;
      if (rsp_valid) begin
        w_got       = 1'b1;
        w_lat       = cyc - 1;
        w_tck_rsp   = tck;
        w_busy_rsp  = busy;
        w_ready_rsp = cmd_ready;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   rises;
    logic saw, prev;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_len   = 6'd0;
    cmd_data  = '0;
    loopback  = 1'b1;
    tdo_fix   = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tck",       64'(tck),       64'd0);
    check("rst_tms",       64'(tms),       64'd1);
    check("rst_tdi",       64'(tdi),       64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_err",   64'(rsp_err),   64'd0);
    check("rst_rsp_data",  64'(rsp_data),  64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(cmd_ready), 64'd1);

    // Loopback DR scan, len 8, 0xA5
    send(2'b00, 6'd8, ML'(8'hA5));
    watch(300);
    check("dr8_got",       64'(w_got),       64'd1);
    check("dr8_latency",   64'(w_lat),       64'd104);
    check("dr8_tck_count", 64'(w_ntck),      64'd13);
    check("dr8_tms_seq",   w_tms,            64'hC01);
    check("dr8_tdi_seq",   w_tdi,            64'h528);
    check("dr8_rsp_data",  64'(rsp_data),    64'hA5);
    check("dr8_rsp_err",   64'(rsp_err),     64'd0);
    check("dr8_tck_at_rsp",64'(w_tck_rsp),   64'd0);
    check("dr8_busy_c1",   64'(w_busy1),     64'd1);
    check("dr8_ready_c1",  64'(w_ready1),    64'd0);
    check("dr8_busy_rsp",  64'(w_busy_rsp),  64'd1);
    check("dr8_ready_rsp", 64'(w_ready_rsp), 64'd0);
    @(negedge clk);
    check("dr8_ready_after", 64'(cmd_ready), 64'd1);
    check("dr8_busy_after",  64'(busy),      64'd0);
    check("dr8_pulse_width", 64'(rsp_valid), 64'd0);
    check("dr8_data_hold",   64'(rsp_data),  64'hA5);

    // IR scan, len 2, data 2'b10, tdo tied high
    loopback = 1'b0;
    tdo_fix  = 1'b1;
    send(2'b01, 6'd2, ML'(2'b10));
    watch(300);
    check("ir2_got",       64'(w_got),    64'd1);
    check("ir2_latency",   64'(w_lat),    64'd64);
    check("ir2_tck_count", 64'(w_ntck),   64'd8);
    check("ir2_tms_seq",   w_tms,         64'h63);
    check("ir2_tdi_seq",   w_tdi,         64'h20);
    check("ir2_rsp_data",  64'(rsp_data), 64'h3);
    check("ir2_rsp_err",   64'(rsp_err),  64'd0);

    // Rejected commands: len 0, len 39, op 11
    send(2'b00, 6'd0, ML'(8'hFF));
    watch(20);
    check("len0_latency", 64'(w_lat),     64'd1);
    check("len0_err",     64'(rsp_err),   64'd1);
    check("len0_no_tck",  64'(w_ntck),    64'd0);
    check("len0_data",    64'(rsp_data),  64'h3);
    check("len0_busy_c1", 64'(w_busy1),   64'd1);
    send(2'b00, 6'd39, ML'(8'hFF));
    watch(20);
    check("len39_latency", 64'(w_lat),    64'd1);
    check("len39_err",     64'(rsp_err),  64'd1);
    check("len39_no_tck",  64'(w_ntck),   64'd0);
    check("len39_data",    64'(rsp_data), 64'h3);
    send(2'b11, 6'd4, ML'(8'hFF));
    watch(20);
    check("op3_latency", 64'(w_lat),      64'd1);
    check("op3_err",     64'(rsp_err),    64'd1);
    check("op3_no_tck",  64'(w_ntck),     64'd0);
    check("op3_tck_rsp", 64'(w_tck_rsp),  64'd0);
    check("op3_data",    64'(rsp_data),   64'h3);

    // TAP reset
    send(2'b10, 6'd8, ML'(8'hFF));
    watch(300);
    check("tap_rst_latency", 64'(w_lat),    64'd48);
    check("tap_rst_tck",     64'(w_ntck),   64'd6);
    check("tap_rst_tms_seq", w_tms,         64'h1F);
    check("tap_rst_tdi_seq", w_tdi,         64'h0);
    check("tap_rst_data",    64'(rsp_data), 64'h0);
    check("tap_rst_err",     64'(rsp_err),  64'd0);

    // Back-to-back DR scans with cmd_valid held high
    loopback = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_len   = 6'd4;
    cmd_data  = ML'(4'h9);
    check("b2b_ready_first", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    cmd_data  = ML'(4'h6);
    watch(200);
    check("b2b_first_latency", 64'(w_lat),    64'd72);
    check("b2b_first_data",    64'(rsp_data), 64'h9);
    @(negedge clk);
    check("b2b_ready_second", 64'(cmd_ready), 64'd1);
    check("b2b_tck_gap",      64'(tck),       64'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    watch(200);
    check("b2b_second_latency", 64'(w_lat),    64'd72);
    check("b2b_second_tck",     64'(w_ntck),   64'd9);
    check("b2b_second_data",    64'(rsp_data), 64'h6);

    // Reset in the middle of a 38-bit scan
    send(2'b00, 6'd38, 38'h2A_5A5A5A5A);
    saw   = 1'b0;
    prev  = 1'b0;
    rises = 0;
    for (int c = 0; c < 400 && rises < 20; c++) begin
      @(negedge clk);
      if (tck && !prev) rises++;
      prev = tck;
      if (rsp_valid) saw = 1'b1;
    end
    check("mid_reached_cycle20", 64'(rises), 64'd20);
    reset = 1'b1;
    @(negedge clk);
    if (rsp_valid) saw = 1'b1;
    check("mid_tck",       64'(tck),       64'd0);
    check("mid_tms",       64'(tms),       64'd1);
    check("mid_tdi",       64'(tdi),       64'd0);
    check("mid_busy",      64'(busy),      64'd0);
    check("mid_cmd_ready", 64'(cmd_ready), 64'd0);
    check("mid_rsp_err",   64'(rsp_err),   64'd0);
    check("mid_rsp_data",  64'(rsp_data),  64'd0);
    reset = 1'b0;
    @(negedge clk);
    if (rsp_valid) saw = 1'b1;
    check("mid_no_rsp_valid", 64'(saw),       64'd0);
    check("mid_ready_after",  64'(cmd_ready), 64'd1);

    send(2'b00, 6'd38, 38'h2A_5A5A5A5A);
    watch(600);
    check("dr38_latency",  64'(w_lat),    64'd344);
    check("dr38_tck",      64'(w_ntck),   64'd43);
    check("dr38_rsp_data", 64'(rsp_data), 64'h2A_5A5A5A5A);
    check("dr38_rsp_err",  64'(rsp_err),  64'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
